diff_reg_scan: RTL and testbench
================================

DIFF_REG_SCAN -- requirements
Module: diff_reg_scan

Interface
REQ-001 SHALL have parameter XLEN, 64, register/data width (`RegBus).
REQ-002 SHALL have parameter NREG, 32, number of architectural registers (`RegNum).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 SHALL have port start_i  input  1  request one snapshot scan.
REQ-006 SHALL have port pc_i  input  XLEN  commit PC, captured as the header beat.
REQ-007 SHALL have port raddr_o  output  5  address driven to the register file read port.
REQ-008 SHALL have port rdata_i  input  XLEN  register file read data, combinational from raddr_o.
REQ-009 SHALL have port out_valid_o  output  1  stream beat valid.
REQ-010 SHALL have port out_ready_i  input  1  stream consumer ready.
REQ-011 SHALL have port out_data_o  output  XLEN  stream beat payload.
REQ-012 SHALL have port out_idx_o  output  6  beat index: 0 = PC, k = x(k-1) for k in 1..32.
REQ-013 SHALL have port out_last_o  output  1  final beat marker.
REQ-014 SHALL have port busy_o  output  1  scan in progress.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-016 SHALL implement two states: IDLE and SEND; busy_o = 1 exactly in SEND.
REQ-017 In IDLE with start_i = 1, SHALL on the next edge load out_data_o <= pc_i, out_idx_o <= 0, out_valid_o <= 1, and enter SEND.
REQ-018 In SEND, raddr_o SHALL equal out_idx_o[4:0], the register carried by the next beat; in IDLE raddr_o SHALL be 0.
REQ-019 A beat SHALL transfer on a cycle where out_valid_o = 1 and out_ready_i = 1.
REQ-020 On a transfer with out_idx_o < 32, SHALL load out_data_o <= rdata_i and increment out_idx_o, keeping out_valid_o = 1 with no bubble.
REQ-021 On a transfer with out_idx_o = 32, SHALL clear out_valid_o, pulse done_o for one cycle, and return to IDLE.
REQ-022 While out_valid_o = 1 and out_ready_i = 0, out_data_o, out_idx_o, and out_last_o SHALL stay stable.
REQ-023 out_last_o SHALL equal out_valid_o AND (out_idx_o = 32).
REQ-024 Each scan SHALL emit exactly 33 beats in index order 0..32; minimum latency is 33 cycles from the first valid beat to done_o with out_ready_i held at 1.
REQ-025 Beat k (k >= 1) SHALL carry rdata_i sampled at the transfer cycle of beat k-1; the x0 beat SHALL carry whatever the read port returns for address 0, which is 0.
REQ-026 Snapshot atomicity SHALL be the integrator's responsibility: commits to the register file are held while busy_o = 1.
REQ-027 start_i SHALL be ignored while in SEND and in the cycle done_o is asserted; start_i SHALL be accepted again the cycle after done_o.
REQ-028 out_idx_o SHALL never exceed 32 and SHALL not wrap.

Reset
REQ-029 With rst = 0 at a rising edge, SHALL enter IDLE with out_valid_o = 0, out_data_o = 0, out_idx_o = 0, out_last_o = 0, busy_o = 0, done_o = 0, and raddr_o = 0.
REQ-030 Reset asserted mid-scan SHALL abort the scan immediately, with no done_o pulse and no further beats.
REQ-031 start_i sampled during reset SHALL be discarded.

Verification
REQ-032 Full-rate scan: regfile xk = 0x1000+k, pc_i = 0x80000000, out_ready_i = 1 -> beats 0x80000000, 0, 0x1001..0x101F on idx 0..32; out_last_o on idx 32; done_o on the next cycle.
REQ-033 Backpressure: out_ready_i toggles 1,0,0,1 repeatedly -> identical 33-beat sequence; payload and index stable during every stall.
REQ-034 Start during busy: start_i pulsed at idx 5 -> ignored, exactly 33 beats; start_i one cycle after done_o -> new scan begins.
REQ-035 Reset mid-scan: rst = 0 at idx 17 -> next cycle out_valid_o = 0, busy_o = 0, no done_o; a following start_i yields a full 33-beat scan.
REQ-036 Last-beat stall: out_ready_i = 0 while idx = 32 for 4 cycles -> out_last_o held at 1, done_o stays 0 until the transfer.

Source files
------------

// File: rtl/diff_reg_scan_if.sv
// diff_reg_scan_if
//   Bundles the scan request, the register-file read port and the
//   outbound snapshot stream into one interface.
//
//   master : the scanner side. It drives raddr_o and the out_* stream,
//            plus busy_o and done_o.
//   slave  : the integrator side. It drives start_i, pc_i, rdata_i and
//            out_ready_i.
//
//   XLEN must match the XLEN of the diff_reg_scan instance attached to it.
interface diff_reg_scan_if #(
    parameter int XLEN = 64
);
    logic            start_i;
    logic [XLEN-1:0] pc_i;
    logic [4:0]      raddr_o;
    logic [XLEN-1:0] rdata_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_data_o;
    logic [5:0]      out_idx_o;
    logic            out_last_o;
    logic            busy_o;
    logic            done_o;

    modport master (
        input  start_i, pc_i, rdata_i, out_ready_i,
        output raddr_o, out_valid_o, out_data_o, out_idx_o, out_last_o,
               busy_o, done_o
    );

    modport slave (
        output start_i, pc_i, rdata_i, out_ready_i,
        input  raddr_o, out_valid_o, out_data_o, out_idx_o, out_last_o,
               busy_o, done_o
    );
endinterface

// File: rtl/diff_reg_scan.sv
// diff_reg_scan
//   Streams one architectural-state snapshot as a valid/ready beat sequence.
//   Beat 0 carries the commit PC. Beats 1..NREG carry x0..x(NREG-1), read
//   one per beat through the register-file read port.
//
//   Ports
//     clk  : sole clock, rising edge
//     rst  : synchronous, active-low reset
//     bus  : diff_reg_scan_if.master
//            start_i / pc_i            scan request and the header payload
//            raddr_o / rdata_i         combinational register-file read
//            out_valid_o / out_ready_i stream handshake
//            out_data_o / out_idx_o    payload and beat index
//            out_last_o                marks the final beat
//            busy_o                    high while a scan is in flight
//            done_o                    one-cycle pulse after the final transfer
//
//   The read port is always addressed with the register that the *next*
//   beat carries, which is out_idx_o[4:0]. Beat k (register x(k-1)) is
//   therefore already sitting on rdata_i when beat k-1 transfers. That lets
//   the stream run at full rate with no bubble and no extra read-data
//   register. The register file must not change while busy_o is high.
module diff_reg_scan #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic           clk,
    input  logic           rst,
    diff_reg_scan_if.master bus
);
    // Index of the final beat. Beat 0 is the PC, so the last beat is NREG.
    localparam logic [5:0] LAST_IDX = 6'(NREG);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state;
    logic [XLEN-1:0] data_q;
    logic [5:0]      idx_q;
    logic            valid_q;
    logic            done_q;

    logic xfer;
    logic at_last;

    assign xfer    = valid_q && bus.out_ready_i;
    assign at_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Reset aborts any scan outright. There is no done pulse, and a
            // start_i seen on this edge is dropped.
            state   <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // The cycle that shows done_o also refuses a new start.
                    // The scanner re-arms on the following cycle.
                    if (bus.start_i && !done_q) begin
                        data_q  <= bus.pc_i;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (at_last) begin
                            // idx_q is left parked at LAST_IDX. With valid
                            // low, out_last_o still reads 0.
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            data_q <= bus.rdata_i;
                            idx_q  <= idx_q + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = (state == SEND);
    assign bus.raddr_o     = (state == SEND) ? idx_q[4:0] : 5'd0;
    assign bus.out_valid_o = valid_q;
    assign bus.out_data_o  = data_q;
    assign bus.out_idx_o   = idx_q;
    assign bus.out_last_o  = valid_q && at_last;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_diff_reg_scan.sv
module tb_diff_reg_scan;
    typedef struct {
        logic [63:0] data;
        int          idx;
    } beat_t;

    logic clk;
    logic rst;
    logic [63:0] regs [32];
    beat_t q[$];
    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 0;
    bit last_xfer_prev = 0;

    diff_reg_scan_if #(.XLEN(64)) bus ();

    diff_reg_scan #(.XLEN(64), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file model: combinational read.
    assign bus.rdata_i = regs[bus.raddr_o];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle check of the DUT against the scoreboard front.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", bus.out_valid_o, (q.size() != 0));
            chk("busy",  bus.busy_o,      (q.size() != 0));
            chk("done",  bus.done_o,      last_xfer_prev);
            if (q.size() != 0) begin
                beat_t b;
                logic [4:0] ra;
                b  = q[0];
                ra = b.idx[4:0];
                chk("data",  bus.out_data_o, b.data);
                chk("idx",   bus.out_idx_o,  b.idx);
                chk("last",  bus.out_last_o, (b.idx == 32));
                chk("raddr", bus.raddr_o,    ra);
            end else begin
                chk("last_idle",  bus.out_last_o, 0);
                chk("raddr_idle", bus.raddr_o,    0);
            end
            last_xfer_prev = 0;
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    last_xfer_prev = (q[0].idx == 32) && rst;
                    void'(q.pop_front());
                end
            end
        end
    end

    // Drive start for one cycle, then queue the 33 beats this scan must emit.
    task automatic begin_scan(input logic [63:0] pc);
        bus.start_i = 1;
        bus.pc_i    = pc;
        tick();
        bus.start_i = 0;
        bus.pc_i    = {$urandom, $urandom};
        q.push_back('{data: pc, idx: 0});
        for (int k = 1; k <= 32; k++) q.push_back('{data: regs[k-1], idx: k});
    endtask

    // mode 0: ready held high; 1: ready 1,0,0,1; 2: 4-cycle stall on idx 32;
    // 3: stray start at idx 5. rst_at >= 0 resets the DUT when that idx shows.
    task automatic run(input int mode, input int rst_at);
        int stalls = 0;
        bit pulsed = 0;
        bit fin = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            case (mode)
                1: bus.out_ready_i = (c % 4 == 0) || (c % 4 == 3);
                2: begin
                    if (bus.out_idx_o == 32 && stalls < 4) begin
                        bus.out_ready_i = 0;
                        stalls++;
                    end else begin
                        bus.out_ready_i = 1;
                    end
                end
                default: bus.out_ready_i = 1;
            endcase
            if (mode == 3 && bus.out_idx_o == 5 && !pulsed) begin
                bus.start_i = 1;
                pulsed = 1;
            end else begin
                bus.start_i = 0;
            end
            if (rst_at >= 0 && bus.out_idx_o == 6'(rst_at)) begin
                rst = 0;
                tick();
                chk("rst_valid", bus.out_valid_o, 0);
                chk("rst_busy",  bus.busy_o,      0);
                chk("rst_done",  bus.done_o,      0);
                rst = 1;
                q.delete();
                tick();
                chk("rst_no_done",  bus.done_o,      0);
                chk("rst_no_beats", bus.out_valid_o, 0);
                fin = 1;
            end else begin
                tick();
                if (bus.done_o) fin = 1;
            end
        end
        if (!fin) chk("timeout", 0, 1);
        if (rst_at < 0) chk("queue_empty", q.size(), 0);
        if (mode == 2) chk("stall_cycles", stalls, 4);
        bus.out_ready_i = 1;
        bus.start_i     = 0;
    endtask

    initial begin
        regs[0] = 64'h0;
        for (int k = 1; k < 32; k++) regs[k] = 64'h1000 + 64'(k);
        rst             = 0;
        bus.start_i     = 1;
        bus.pc_i        = 64'hdead_beef;
        bus.out_ready_i = 1;

        // Reset, with start_i held high across it.
        tick();
        tick();
        chk("rst_data",  bus.out_data_o,  0);
        chk("rst_idx",   bus.out_idx_o,   0);
        chk("rst_vld",   bus.out_valid_o, 0);
        chk("rst_last",  bus.out_last_o,  0);
        chk("rst_bsy",   bus.busy_o,      0);
        chk("rst_dn",    bus.done_o,      0);
        chk("rst_raddr", bus.raddr_o,     0);
        rst         = 1;
        bus.start_i = 0;
        mon_en      = 1;
        tick();
        chk("start_in_reset", bus.out_valid_o, 0);

        // Full-rate scan.
        begin_scan(64'h8000_0000);
        run(0, -1);
        tick();
        tick();

        // Backpressure pattern.
        begin_scan(64'h8000_1234);
        run(1, -1);
        tick();

        // Stray start mid-scan, then start held from the done cycle onward.
        begin_scan(64'h4000_0000);
        run(3, -1);
        bus.start_i = 1;
        tick();
        chk("start_on_done", bus.out_valid_o, 0);
        begin_scan(64'h4000_0040);
        run(0, -1);
        tick();

        // Stall on the final beat.
        begin_scan(64'hffff_ffff_ffff_fffc);
        run(2, -1);
        tick();

        // Reset mid-scan, then a clean scan.
        begin_scan(64'h2222_0000);
        run(0, 17);
        begin_scan(64'h3333_0000);
        run(0, -1);
        tick();

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
